// File: rtl/pmod_jstk_responder_pkg.sv
// Shared definitions for the PmodJSTK responder: frame geometry,
// responder state encoding and the frame packing helper.
package jstk_pkg;

    localparam int unsigned JSTK_NUM_BYTES     = 5;
    localparam int unsigned JSTK_FRAME_W       = 40;
    localparam int unsigned JSTK_CMD_VALID_BIT = 7;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        COMPLETE
    } jstk_state_e;

    // Byte order on the wire: X low, X high, Y low, Y high, buttons.
    function automatic logic [JSTK_FRAME_W-1:0] jstk_pack(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
    endfunction

endpackage

// File: rtl/pmod_jstk_responder_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
// The chain resets to 0, so a line already high at reset release yields a
// rise pulse and a line already low yields nothing.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic board_clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next values of the synchronizer chain and the delayed level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/pmod_jstk_responder.sv
// SPI mode-0 slave emulating a PmodJSTK joystick: returns X, Y and buttons
// in a 5-byte frame and latches the LED command byte from the master.
// Optional build macro JSTK_TRISTATE_EN adds a miso_oe output for an
// external tristate buffer.
module pmod_jstk_responder
    import jstk_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_MISO   = 1'b0
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       frame_done,
`ifdef JSTK_TRISTATE_EN
    output logic       frame_error,
    output logic       miso_oe
`else
    output logic       frame_error
`endif
);

    logic sck_rise;
    logic sck_fall;
    logic ss_rise;
    logic ss_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .board_clk (board_clk),
        .reset     (reset),
        .din       (sclk),
        .rise      (sck_rise),
        .fall      (sck_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .board_clk (board_clk),
        .reset     (reset),
        .din       (ss_n),
        .rise      (ss_rise),
        .fall      (ss_fall)
    );

    // mosi needs only the level, aligned with the sclk synchronizer depth.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_d;
    logic                   mosi_s;

    jstk_state_e             state_q,      state_d;
    logic [JSTK_FRAME_W-1:0] tx_q,         tx_d;
    logic [7:0]              rx_q,         rx_d;
    logic [2:0]              bit_cnt_q,    bit_cnt_d;
    logic [2:0]              byte_cnt_q,   byte_cnt_d;
    logic [1:0]              led_q,        led_d;
    logic                    miso_q,       miso_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_error_q, frame_error_d;

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Frame sequencing: state transitions, shift registers, counters, outputs.
    always_comb begin
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        state_d       = state_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        led_d         = led_q;
        miso_d        = miso_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        // Deselect outranks any sclk edge in the same cycle.
        if (ss_rise) begin
            if (state_q == ACTIVE && byte_cnt_q < 3'(JSTK_NUM_BYTES)) begin
                frame_error_d = 1'b1;
            end
            state_d = IDLE;
            miso_d  = IDLE_MISO;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_d = IDLE_MISO;
                    if (ss_fall) begin
                        state_d    = ACTIVE;
                        tx_d       = jstk_pack(x_pos, y_pos, buttons);
                        rx_d       = '0;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        miso_d     = tx_d[JSTK_FRAME_W-1];
                    end
                end
                ACTIVE: begin
                    if (sck_rise) begin
                        rx_d      = {rx_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            if (byte_cnt_q == 3'd0 && rx_d[JSTK_CMD_VALID_BIT]) begin
                                led_d = rx_d[1:0];
                            end
                            if (byte_cnt_d == 3'(JSTK_NUM_BYTES)) begin
                                frame_done_d = 1'b1;
                                state_d      = COMPLETE;
                            end
                        end
                    end else if (sck_fall) begin
                        tx_d = {tx_q[JSTK_FRAME_W-2:0], 1'b0};
                    end
                    miso_d = (state_d == COMPLETE) ? 1'b0 : tx_d[JSTK_FRAME_W-1];
                end
                COMPLETE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    miso_d  = IDLE_MISO;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            mosi_sync_q   <= '0;
            state_q       <= IDLE;
            tx_q          <= '0;
            rx_q          <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            led_q         <= 2'b00;
            miso_q        <= IDLE_MISO;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            led_q         <= led_d;
            miso_q        <= miso_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign miso        = miso_q;
    assign led         = led_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;

`ifdef JSTK_TRISTATE_EN
    assign miso_oe = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Self-checking bench for pmod_jstk_responder: table of directed frames,
// hand sequences for LED/abort/reset corners, then randomized frames
// checked against a byte-level model of the joystick frame.
module tb_pmod_jstk_responder;

    localparam int HOLD = 6;

    logic       board_clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] buttons;
    logic [1:0] led;
    logic       frame_done;
    logic       frame_error;
`ifdef JSTK_TRISTATE_EN
    logic       miso_oe;
`endif

    pmod_jstk_responder #(
        .SYNC_STAGES (2),
        .IDLE_MISO   (1'b1)
    ) dut (
        .board_clk   (board_clk),
        .reset       (reset),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .buttons     (buttons),
        .led         (led),
        .frame_done  (frame_done),
`ifdef JSTK_TRISTATE_EN
        .frame_error (frame_error),
        .miso_oe     (miso_oe)
`else
        .frame_error (frame_error)
`endif
    );

    always #5 board_clk = ~board_clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Count cycles in which each pulse output is high.
    always @(negedge board_clk) begin
        if (frame_done === 1'b1)  done_cnt <= done_cnt + 1;
        if (frame_error === 1'b1) err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Mode-0 master: mosi set while sclk low, miso sampled just before each rise.
    task automatic spi_xfer(input int nbits, input logic [47:0] mo, input int chg_bit,
                            input logic [9:0] chg_x, input bit end_ss, output logic [47:0] mi);
        mi = '0;
        @(posedge board_clk); #1 ss_n = 1'b0;
        repeat (8) @(posedge board_clk);
        for (int i = 0; i < nbits; i++) begin
            #1;
            if (i == chg_bit) x_pos = chg_x;
            mosi = mo[47-i];
            repeat (HOLD) @(posedge board_clk);
            #1 mi[47-i] = miso;
            sclk = 1'b1;
            repeat (HOLD) @(posedge board_clk);
            #1 sclk = 1'b0;
        end
        repeat (HOLD) @(posedge board_clk);
        if (end_ss) begin
            #1 ss_n = 1'b1;
            repeat (10) @(posedge board_clk);
        end
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [7:0]  cmd;
        int          nbits;
        int          chg_bit;
        logic [9:0]  chg_x;
        logic [47:0] exp_mi;
        logic [1:0]  exp_led;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        logic [47:0] mi;
        int d0, e0;
        x_pos = v.x; y_pos = v.y; buttons = v.btn;
        d0 = done_cnt; e0 = err_cnt;
        spi_xfer(v.nbits, {v.cmd, 40'h0}, v.chg_bit, v.chg_x, 1'b1, mi);
        check("vec_miso_data", mi, v.exp_mi);
        check("vec_led", led, v.exp_led);
        check("vec_done_pulses", 64'(done_cnt - d0), 64'(v.exp_done));
        check("vec_err_pulses", 64'(err_cnt - e0), 64'(v.exp_err));
        check("vec_idle_miso", miso, 1'b1);
`ifdef JSTK_TRISTATE_EN
        check("vec_oe_idle", miso_oe, 1'b0);
`endif
    endtask

    initial begin
        logic [47:0] mi;
        logic [47:0] mask;
        logic [47:0] expv;
        logic [1:0]  led_m;
        int d0, e0;
        int nbits, xi, yi, bi, ci;

        vecs[0] = '{10'h2A5, 10'h0F3, 3'b101, 8'h80, 40, -1, 10'h0, 48'hA5_02_F3_00_05_00, 2'b00, 1, 0};
        vecs[1] = '{10'h3FF, 10'h200, 3'b111, 8'h83, 40, -1, 10'h0, 48'hFF_03_00_02_07_00, 2'b11, 1, 0};
        vecs[2] = '{10'h155, 10'h0AA, 3'b010, 8'h01, 40, -1, 10'h0, 48'h55_01_AA_00_02_00, 2'b11, 1, 0};
        vecs[3] = '{10'h2A5, 10'h0F3, 3'b101, 8'h00, 13, -1, 10'h0, 48'hA5_00_00_00_00_00, 2'b11, 0, 1};
        vecs[4] = '{10'h2A5, 10'h0F3, 3'b101, 8'h80, 40, -1, 10'h0, 48'hA5_02_F3_00_05_00, 2'b00, 1, 0};
        vecs[5] = '{10'h155, 10'h000, 3'b000, 8'h00, 40, 12, 10'h3FF, 48'h55_01_00_00_00_00, 2'b00, 1, 0};
        vecs[6] = '{10'h3FF, 10'h000, 3'b000, 8'h00, 40, -1, 10'h0, 48'hFF_03_00_00_00_00, 2'b00, 1, 0};
        vecs[7] = '{10'h2A5, 10'h0F3, 3'b101, 8'h00, 48, -1, 10'h0, 48'hA5_02_F3_00_05_00, 2'b00, 1, 0};

        reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        x_pos = '0; y_pos = '0; buttons = '0;
        repeat (5) @(posedge board_clk);
        #1;
        check("reset_miso", miso, 1'b1);
        check("reset_led", led, 2'b00);
        check("reset_done", frame_done, 1'b0);
        check("reset_err", frame_error, 1'b0);
`ifdef JSTK_TRISTATE_EN
        check("reset_oe", miso_oe, 1'b0);
`endif
        reset = 1'b0;
        repeat (10) @(posedge board_clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // LED latched as soon as byte0 completes, and kept through an abort.
        d0 = done_cnt; e0 = err_cnt;
        spi_xfer(8, 48'h82_00_00_00_00_00, -1, 10'h0, 1'b0, mi);
        check("led_after_byte0", led, 2'b10);
`ifdef JSTK_TRISTATE_EN
        check("oe_in_frame", miso_oe, 1'b1);
`endif
        #1 ss_n = 1'b1;
        repeat (10) @(posedge board_clk);
        check("abort8_err", 64'(err_cnt - e0), 64'd1);
        check("abort8_done", 64'(done_cnt - d0), 64'd0);
        check("abort8_led_kept", led, 2'b10);

        // Reset at bit 20 with ss_n still low through release.
        x_pos = 10'h2A5; y_pos = 10'h0F3; buttons = 3'b101;
        d0 = done_cnt; e0 = err_cnt;
        spi_xfer(20, 48'h83_00_00_00_00_00, -1, 10'h0, 1'b0, mi);
        check("pre_reset_led", led, 2'b11);
        #1 reset = 1'b1;
        #1;
        check("midreset_led", led, 2'b00);
        check("midreset_miso", miso, 1'b1);
        repeat (3) @(posedge board_clk);
        #1 reset = 1'b0;
        spi_xfer(8, 48'h83_00_00_00_00_00, -1, 10'h0, 1'b1, mi);
        check("post_reset_no_frame", mi[47:40], 8'hFF);
        check("post_reset_led", led, 2'b00);
        check("reset_no_done", 64'(done_cnt - d0), 64'd0);
        check("reset_no_err", 64'(err_cnt - e0), 64'd0);

        // Randomized frames against a byte-level model.
        led_m = 2'b00;
        for (int k = 0; k < 24; k++) begin
            xi = int'($urandom_range(0, 1023));
            yi = int'($urandom_range(0, 1023));
            bi = int'($urandom_range(0, 7));
            ci = int'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0, 1:    nbits = 40;
                2:       nbits = 40 + int'($urandom_range(1, 8));
                default: nbits = int'($urandom_range(1, 39));
            endcase
            x_pos = 10'(xi); y_pos = 10'(yi); buttons = 3'(bi);
            expv = {8'(xi % 256), 8'(xi / 256), 8'(yi % 256), 8'(yi / 256), 8'(bi), 8'h00};
            mask = '1;
            mask = mask << (48 - nbits);
            if (nbits >= 8 && ci >= 128) led_m = 2'(ci % 4);
            d0 = done_cnt; e0 = err_cnt;
            spi_xfer(nbits, {8'(ci), 32'($urandom), 8'($urandom)}, -1, 10'h0, 1'b1, mi);
            check("rnd_miso_data", mi, expv & mask);
            check("rnd_led", led, led_m);
            check("rnd_done", 64'(done_cnt - d0), (nbits >= 40) ? 64'd1 : 64'd0);
            check("rnd_err", 64'(err_cnt - e0), (nbits >= 40) ? 64'd0 : 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
